// File: rtl/lsu_apb_if.sv
// Core request/response and APB bus bundle for lsu_apb_master.
// master: the LSU side (consumes requests, drives APB); slave: core + memory.
interface lsu_apb_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic [ADDR_W-1:0] paddr;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [3:0]        pstrb;
  logic [31:0]       pwdata;
  logic [31:0]       prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    input  req_valid, req_we, req_funct3,
    input  req_addr, req_wdata,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    output paddr, psel, penable, pwrite,
    output pstrb, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    output req_valid, req_we, req_funct3,
    output req_addr, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    input  paddr, psel, penable, pwrite,
    input  pstrb, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/lsu_apb_master.sv
// Load/store unit: one core request at a time onto an APB data bus.
// Ports: clk, rst (async active-high), bus (lsu_apb_if.master).
module lsu_apb_master #(
  parameter int ADDR_W = 32
) (
  input logic        clk,
  input logic        rst,
  lsu_apb_if.master  bus
);
  typedef enum logic [1:0] {
    IDLE, SETUP, ACCESS, RESP
  } state_t;

  state_t     state;
  logic       we_q;
  logic [2:0] f3_q;
  logic [1:0] off_q;

  logic [2:0]  f3;
  logic [1:0]  off;
  logic        bad_f3;
  logic        bad_align;
  logic [3:0]  strb;
  logic [31:0] wdata;
  logic [15:0] sh;
  logic [31:0] ld;

  assign f3  = bus.req_funct3;
  assign off = bus.req_addr[1:0];

  // f3[1:0] is the access size for both loads and stores.
  always_comb begin
    bad_f3 = 1'b0;
    if (bus.req_we)
      bad_f3 = f3[2] | (f3[1:0] == 2'b11);
    else
      bad_f3 = (f3[1:0] == 2'b11) | (f3[2] & f3[1]);
    bad_align = ((f3[1:0] == 2'b01) & off[0])
              | ((f3[1:0] == 2'b10) & (off != 2'b00));
  end

  always_comb begin
    strb  = 4'b0000;
    wdata = 32'h0;
    if (bus.req_we) begin
      case (f3[1:0])
        2'b00: begin
          strb  = 4'b0001 << off;
          wdata = {4{bus.req_wdata[7:0]}};
        end
        2'b01: begin
          strb  = 4'b0011 << off;
          wdata = {2{bus.req_wdata[15:0]}};
        end
        2'b10: begin
          strb  = 4'b1111;
          wdata = bus.req_wdata;
        end
        default: ;
      endcase
    end
  end

  // Only the low halfword of the lane-shifted data is ever needed.
  always_comb begin
    sh = 16'(bus.prdata >> {off_q, 3'b000});
    case (f3_q)
      3'b000:  ld = {{24{sh[7]}}, sh[7:0]};
      3'b100:  ld = {24'h0, sh[7:0]};
      3'b001:  ld = {{16{sh[15]}}, sh};
      3'b101:  ld = {16'h0, sh};
      default: ld = bus.prdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      we_q          <= 1'b0;
      f3_q          <= 3'b000;
      off_q         <= 2'b00;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= 32'h0;
      bus.rsp_err   <= 1'b0;
      bus.paddr     <= '0;
      bus.psel      <= 1'b0;
      bus.penable   <= 1'b0;
      bus.pwrite    <= 1'b0;
      bus.pstrb     <= 4'b0000;
      bus.pwdata    <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            we_q          <= bus.req_we;
            f3_q          <= f3;
            off_q         <= off;
            bus.req_ready <= 1'b0;
            if (!(bad_f3 || bad_align)) begin
              state       <= SETUP;
              bus.psel    <= 1'b1;
              bus.penable <= 1'b0;
              bus.paddr   <= {bus.req_addr[ADDR_W-1:2], 2'b00};
              bus.pwrite  <= bus.req_we;
              bus.pstrb   <= strb;
              bus.pwdata  <= wdata;
            end else begin
              // Illegal: answer immediately, never touch the bus.
              state         <= RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= 1'b1;
              bus.rsp_rdata <= 32'h0;
            end
          end
        end
        SETUP: begin
          bus.penable <= 1'b1;
          state       <= ACCESS;
        end
        ACCESS: begin
          if (bus.pready) begin
            bus.psel      <= 1'b0;
            bus.penable   <= 1'b0;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= bus.pslverr;
            bus.rsp_rdata <= (bus.pslverr || we_q) ? 32'h0 : ld;
            state         <= RESP;
          end
        end
        RESP: begin
          bus.rsp_valid <= 1'b0;
          bus.rsp_err   <= 1'b0;
          bus.rsp_rdata <= 32'h0;
          bus.req_ready <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_apb_master.sv
// Directed testbench for lsu_apb_master.
// Drives requests and a scripted APB responder; checks hand-computed values.
module tb_lsu_apb_master;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  lsu_apb_if #(.ADDR_W(32)) bus ();

  lsu_apb_master #(.ADDR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Present one request and return in the first cycle after acceptance.
  task automatic issue(
    input logic        we,
    input logic [2:0]  f3,
    input logic [31:0] a,
    input logic [31:0] w
  );
    int n;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      step;
      n++;
    end
    if (!bus.req_ready) begin
      total++;
      bad++;
      $display("FAIL issue_timeout req_ready=%b want=1", bus.req_ready);
    end
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = w;
    step;
    bus.req_valid  = 1'b0;
    bus.req_we     = ~we;
    bus.req_funct3 = 3'b111;
    bus.req_addr   = 32'hFFFF_FFFF;
    bus.req_wdata  = 32'h5555_AAAA;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({bus.req_ready, bus.psel, bus.penable,
         bus.pwrite, bus.pstrb} !== 8'b1000_0000) begin
      bad++;
      $display("FAIL reset_ctl got=%b want=10000000",
               {bus.req_ready, bus.psel, bus.penable,
                bus.pwrite, bus.pstrb});
    end
    total++;
    if ({bus.paddr, bus.pwdata} !== 64'h0) begin
      bad++;
      $display("FAIL reset_bus paddr=%h pwdata=%h want=0",
               bus.paddr, bus.pwdata);
    end
    total++;
    if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== 34'h0) begin
      bad++;
      $display("FAIL reset_rsp v=%b e=%b d=%h want=0",
               bus.rsp_valid, bus.rsp_err, bus.rsp_rdata);
    end
    rst = 1'b0;
    step;
    total++;
    if ({bus.req_ready, bus.psel} !== 2'b10) begin
      bad++;
      $display("FAIL reset_idle got=%b want=10",
               {bus.req_ready, bus.psel});
    end
  endtask

  task automatic test_sw;
    bus.pready  = 1'b1;
    bus.pslverr = 1'b0;
    issue(1'b1, 3'b010, 32'h40, 32'hDEAD_BEEF);
    total++;
    if ({bus.psel, bus.penable, bus.pwrite} !== 3'b101) begin
      bad++;
      $display("FAIL sw_setup got=%b want=101",
               {bus.psel, bus.penable, bus.pwrite});
    end
    total++;
    if (bus.paddr !== 32'h40) begin
      bad++;
      $display("FAIL sw_paddr got=%h want=40", bus.paddr);
    end
    total++;
    if (bus.pstrb !== 4'hF) begin
      bad++;
      $display("FAIL sw_pstrb got=%b want=1111", bus.pstrb);
    end
    total++;
    if (bus.pwdata !== 32'hDEAD_BEEF) begin
      bad++;
      $display("FAIL sw_pwdata got=%h want=deadbeef", bus.pwdata);
    end
    step;
    total++;
    if ({bus.psel, bus.penable, bus.rsp_valid} !== 3'b110) begin
      bad++;
      $display("FAIL sw_access got=%b want=110",
               {bus.psel, bus.penable, bus.rsp_valid});
    end
    step;
    total++;
    if ({bus.rsp_valid, bus.rsp_err, bus.psel, bus.penable}
        !== 4'b1000 || bus.rsp_rdata !== 32'h0) begin
      bad++;
      $display("FAIL sw_resp v/e/sel/en=%b d=%h want=1000 0",
               {bus.rsp_valid, bus.rsp_err, bus.psel, bus.penable},
               bus.rsp_rdata);
    end
    step;
    total++;
    if ({bus.rsp_valid, bus.req_ready} !== 2'b01) begin
      bad++;
      $display("FAIL sw_idle got=%b want=01",
               {bus.rsp_valid, bus.req_ready});
    end
  endtask

  task automatic test_stores;
    logic [2:0]  f3s [4] = '{3'b000, 3'b001, 3'b000, 3'b001};
    logic [31:0] as  [4] = '{32'h43, 32'h42, 32'h40, 32'h40};
    logic [31:0] ws  [4] = '{32'h0000_00A5, 32'h0000_1234,
                             32'hFFFF_FF5A, 32'hABCD_9876};
    logic [3:0]  st  [4] = '{4'b1000, 4'b1100, 4'b0001, 4'b0011};
    logic [31:0] pw  [4] = '{32'hA5A5_A5A5, 32'h1234_1234,
                             32'h5A5A_5A5A, 32'h9876_9876};
    bus.pready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, f3s[i], as[i], ws[i]);
      total++;
      if (bus.pstrb !== st[i] || bus.pwdata !== pw[i]
          || bus.paddr !== 32'h40) begin
        bad++;
        $display("FAIL store%0d strb=%b data=%h addr=%h want %b %h 40",
                 i, bus.pstrb, bus.pwdata, bus.paddr, st[i], pw[i]);
      end
      step;
      step;
      total++;
      if ({bus.rsp_valid, bus.rsp_err} !== 2'b10) begin
        bad++;
        $display("FAIL store%0d_resp got=%b want=10",
                 i, {bus.rsp_valid, bus.rsp_err});
      end
      step;
    end
  endtask

  task automatic test_loads;
    logic [2:0]  f3s [8] = '{3'b000, 3'b100, 3'b001, 3'b001,
                             3'b101, 3'b000, 3'b100, 3'b010};
    logic [31:0] as  [8] = '{32'h42, 32'h42, 32'h42, 32'h40,
                             32'h40, 32'h41, 32'h43, 32'h40};
    logic [31:0] ex  [8] = '{32'hFFFF_FF80, 32'h0000_0080,
                             32'h0000_1280, 32'hFFFF_FF00,
                             32'h0000_FF00, 32'hFFFF_FFFF,
                             32'h0000_0012, 32'h1280_FF00};
    bus.pready = 1'b1;
    bus.prdata = 32'h1280_FF00;
    for (int i = 0; i < 8; i++) begin
      issue(1'b0, f3s[i], as[i], 32'hFFFF_FFFF);
      total++;
      if ({bus.psel, bus.pwrite, bus.pstrb} !== 6'b100000
          || bus.pwdata !== 32'h0) begin
        bad++;
        $display("FAIL load%0d_setup sel/wr/strb=%b wd=%h want=100000 0",
                 i, {bus.psel, bus.pwrite, bus.pstrb}, bus.pwdata);
      end
      step;
      step;
      total++;
      if ({bus.rsp_valid, bus.rsp_err} !== 2'b10
          || bus.rsp_rdata !== ex[i]) begin
        bad++;
        $display("FAIL load%0d v/e=%b data=%h want=10 %h",
                 i, {bus.rsp_valid, bus.rsp_err}, bus.rsp_rdata, ex[i]);
      end
      step;
    end
  endtask

  task automatic test_wait;
    bus.pready = 1'b0;
    bus.prdata = 32'hCAFE_F00D;
    issue(1'b0, 3'b010, 32'h44, 32'h0);
    step;
    for (int c = 2; c <= 5; c++) begin
      if (c == 5) bus.pready = 1'b1;
      total++;
      if ({bus.psel, bus.penable, bus.pwrite, bus.pstrb,
           bus.rsp_valid} !== 8'b1100_0000
          || bus.paddr !== 32'h44) begin
        bad++;
        $display("FAIL wait_c%0d ctl=%b addr=%h want=11000000 44",
                 c, {bus.psel, bus.penable, bus.pwrite, bus.pstrb,
                     bus.rsp_valid}, bus.paddr);
      end
      step;
    end
    total++;
    if ({bus.rsp_valid, bus.rsp_err} !== 2'b10
        || bus.rsp_rdata !== 32'hCAFE_F00D) begin
      bad++;
      $display("FAIL wait_c6 v/e=%b data=%h want=10 cafef00d",
               {bus.rsp_valid, bus.rsp_err}, bus.rsp_rdata);
    end
    step;
  endtask

  task automatic test_illegal;
    logic        wes [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0,
                             1'b0, 1'b0, 1'b1, 1'b1};
    logic [2:0]  f3s [9] = '{3'b010, 3'b001, 3'b010, 3'b001, 3'b011,
                             3'b110, 3'b111, 3'b100, 3'b011};
    logic [31:0] as  [9] = '{32'h41, 32'h43, 32'h42, 32'h41, 32'h40,
                             32'h40, 32'h40, 32'h40, 32'h40};
    bus.pready = 1'b1;
    bus.prdata = 32'h1234_5678;
    for (int i = 0; i < 9; i++) begin
      issue(wes[i], f3s[i], as[i], 32'h1111_1111);
      total++;
      if ({bus.psel, bus.rsp_valid, bus.rsp_err} !== 3'b011
          || bus.rsp_rdata !== 32'h0) begin
        bad++;
        $display("FAIL illegal%0d sel/v/e=%b data=%h want=011 0",
                 i, {bus.psel, bus.rsp_valid, bus.rsp_err},
                 bus.rsp_rdata);
      end
      step;
      total++;
      if ({bus.psel, bus.rsp_valid, bus.req_ready} !== 3'b001) begin
        bad++;
        $display("FAIL illegal%0d_after got=%b want=001",
                 i, {bus.psel, bus.rsp_valid, bus.req_ready});
      end
    end
  endtask

  task automatic test_slverr;
    logic [2:0] f3s [2] = '{3'b010, 3'b000};
    bus.pready  = 1'b1;
    bus.pslverr = 1'b1;
    bus.prdata  = 32'hFFFF_FFFF;
    for (int i = 0; i < 2; i++) begin
      issue(1'b0, f3s[i], 32'h48, 32'h0);
      step;
      step;
      total++;
      if ({bus.rsp_valid, bus.rsp_err} !== 2'b11
          || bus.rsp_rdata !== 32'h0) begin
        bad++;
        $display("FAIL slverr%0d v/e=%b data=%h want=11 0",
                 i, {bus.rsp_valid, bus.rsp_err}, bus.rsp_rdata);
      end
      step;
    end
    bus.pslverr = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [2:0] ex [1:8] = '{3'b100, 3'b100, 3'b010, 3'b001,
                             3'b100, 3'b100, 3'b010, 3'b001};
    bus.pready     = 1'b1;
    bus.prdata     = 32'h1280_FF00;
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h40;
    step;
    bus.req_addr   = 32'h44;
    for (int i = 1; i <= 8; i++) begin
      total++;
      if ({bus.psel, bus.rsp_valid, bus.req_ready} !== ex[i]) begin
        bad++;
        $display("FAIL b2b_c%0d sel/v/rdy=%b want=%b",
                 i, {bus.psel, bus.rsp_valid, bus.req_ready}, ex[i]);
      end
      if (i == 5) begin
        bus.req_valid = 1'b0;
        total++;
        if (bus.paddr !== 32'h44) begin
          bad++;
          $display("FAIL b2b_paddr got=%h want=44", bus.paddr);
        end
      end
      step;
    end
  endtask

  task automatic test_rst_abort;
    bus.pready = 1'b0;
    issue(1'b0, 3'b010, 32'h4C, 32'h0);
    step;
    total++;
    if ({bus.psel, bus.penable} !== 2'b11) begin
      bad++;
      $display("FAIL abort_pre got=%b want=11",
               {bus.psel, bus.penable});
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({bus.psel, bus.penable, bus.rsp_valid, bus.req_ready}
        !== 4'b0001) begin
      bad++;
      $display("FAIL abort_async got=%b want=0001",
               {bus.psel, bus.penable, bus.rsp_valid, bus.req_ready});
    end
    #1 rst = 1'b0;
    bus.pready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step;
      total++;
      if ({bus.psel, bus.rsp_valid, bus.req_ready} !== 3'b001) begin
        bad++;
        $display("FAIL abort_quiet%0d got=%b want=001",
                 i, {bus.psel, bus.rsp_valid, bus.req_ready});
      end
    end
    issue(1'b1, 3'b010, 32'h50, 32'h1122_3344);
    total++;
    if (bus.psel !== 1'b1 || bus.paddr !== 32'h50) begin
      bad++;
      $display("FAIL abort_next sel=%b addr=%h want=1 50",
               bus.psel, bus.paddr);
    end
    step;
    step;
    total++;
    if ({bus.rsp_valid, bus.rsp_err} !== 2'b10) begin
      bad++;
      $display("FAIL abort_next_resp got=%b want=10",
               {bus.rsp_valid, bus.rsp_err});
    end
    step;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout bad=%0d want=finish", bad);
    $fatal(1, "timeout");
  end

  initial begin
    total          = 0;
    bad            = 0;
    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.prdata     = 32'h0;
    bus.pready     = 1'b0;
    bus.pslverr    = 1'b0;
    test_reset;
    test_sw;
    test_stores;
    test_loads;
    test_wait;
    test_illegal;
    test_slverr;
    test_back_to_back;
    test_rst_abort;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
